// File: rtl/if_id_pkg.sv
// Shared constants and entry type for the IF/ID fetch queue.
package if_id_pkg;

    localparam int INSTR_W      = 32;
    localparam int PC_W_DEFAULT = 10;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [PC_W_DEFAULT-1:0] pc_plus4;
        logic [INSTR_W-1:0]      instr;
    } fetch_entry_t;

endpackage

// File: rtl/if_id_entry_ram.sv
// Entry storage for the IF/ID queue: one synchronous write port, one asynchronous read port.
module if_id_entry_ram
    import if_id_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = fetch_entry_t
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  entry_t                   wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output entry_t                   rdata_o
);

    entry_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/if_id_queue.sv
// Fetch buffer between IF and ID: strict FIFO with flush and occupancy count.
// Optional same-cycle bypass when empty is enabled by defining IF_ID_QUEUE_BYPASS_EN.
module if_id_queue
    import if_id_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PC_W  = PC_W_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [PC_W-1:0]          in_pc_plus4,
    input  logic [INSTR_W-1:0]       in_instr,
    output logic                     in_ready,
    input  logic                     flush,
    output logic                     out_valid,
    output logic [PC_W-1:0]          out_pc_plus4,
    output logic [INSTR_W-1:0]       out_instr,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef struct packed {
        logic [PC_W-1:0]    pc_plus4;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          head_valid;
    logic          bypass;
    logic          push;
    logic          pop;
    entry_t        wr_entry;
    entry_t        rd_entry;

    assign head_valid = (count_q != '0);
    assign in_ready   = (count_q < FULL_CNT);

`ifdef IF_ID_QUEUE_BYPASS_EN
    // An empty queue hands the incoming fetch straight to ID instead of storing it.
    assign bypass = !reset && !head_valid && in_valid && out_ready && !flush;
`else
    assign bypass = 1'b0;
`endif

    assign push = in_valid && in_ready && !flush && !bypass;
    assign pop  = head_valid && out_ready && !flush;

    assign wr_entry = '{pc_plus4: in_pc_plus4, instr: in_instr};

    if_id_entry_ram #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_ram (
        .clk     (clk),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_entry),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_entry)
    );

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push && !pop) begin
                count_d = count_q + 1'b1;
            end else if (pop && !push) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // An empty head presents a NOP so ID never sees stale storage contents.
    always_comb begin
        out_valid    = head_valid;
        out_pc_plus4 = '0;
        out_instr    = NOP_INSTR;
        if (bypass) begin
            out_valid    = 1'b1;
            out_pc_plus4 = in_pc_plus4;
            out_instr    = in_instr;
        end else if (head_valid) begin
            out_pc_plus4 = rd_entry.pc_plus4;
            out_instr    = rd_entry.instr;
        end
    end

    assign count = count_q;

endmodule

// File: tb/tb_if_id_queue.sv
// Scoreboard bench for if_id_queue: stimulus pushes expected entries, a negedge monitor pops and compares.
module tb_if_id_queue;
    import if_id_pkg::*;

    localparam int DEPTH = 4;
    localparam int PC_W  = 10;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic               clk = 1'b0;
    logic               reset;
    logic               in_valid;
    logic [PC_W-1:0]    in_pc_plus4;
    logic [31:0]        in_instr;
    logic               in_ready;
    logic               flush;
    logic               out_valid;
    logic [PC_W-1:0]    out_pc_plus4;
    logic [31:0]        out_instr;
    logic               out_ready;
    logic [CW-1:0]      count;

    typedef struct {
        logic [PC_W-1:0] pc;
        logic [31:0]     instr;
    } exp_t;

    exp_t expQ[$];
    int   tests     = 0;
    int   fails     = 0;
    bit   monEnable = 1'b0;
    int   occAtNeg  = 0;
    bit   bypassed  = 1'b0;

    if_id_queue #(
        .DEPTH (DEPTH),
        .PC_W  (PC_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_pc_plus4  (in_pc_plus4),
        .in_instr     (in_instr),
        .in_ready     (in_ready),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_pc_plus4 (out_pc_plus4),
        .out_instr    (out_instr),
        .out_ready    (out_ready),
        .count        (count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs; at the committing edge record what the queue should now hold.
    task automatic applyStimulus(input bit v, input logic [PC_W-1:0] pc, input logic [31:0] ins,
                                 input bit rdy, input bit fl);
        exp_t e;
        in_valid    = v;
        in_pc_plus4 = pc;
        in_instr    = ins;
        out_ready   = rdy;
        flush       = fl;
        @(posedge clk);
        if (fl) begin
            expQ.delete();
        end else if (v && occAtNeg < DEPTH && !bypassed) begin
            e.pc    = pc;
            e.instr = ins;
            expQ.push_back(e);
        end
        #1;
    endtask

    // Monitor: outputs are judged mid-cycle against the head of the expected queue.
    always @(negedge clk) begin
        if (monEnable && !reset) begin
            occAtNeg = expQ.size();
            bypassed = 1'b0;
            checkOutput("count", 32'(count), occAtNeg);
            checkOutput("in_ready", 32'(in_ready), 32'(occAtNeg < DEPTH));
            if (occAtNeg != 0) begin
                checkOutput("out_valid", 32'(out_valid), 1);
                checkOutput("out_pc_plus4", 32'(out_pc_plus4), 32'(expQ[0].pc));
                checkOutput("out_instr", out_instr, expQ[0].instr);
                if (out_ready && !flush) void'(expQ.pop_front());
            end
`ifdef IF_ID_QUEUE_BYPASS_EN
            else if (in_valid && out_ready && !flush) begin
                bypassed = 1'b1;
                checkOutput("bypass_valid", 32'(out_valid), 1);
                checkOutput("bypass_pc", 32'(out_pc_plus4), 32'(in_pc_plus4));
                checkOutput("bypass_instr", out_instr, in_instr);
            end
`endif
            else begin
                checkOutput("empty_valid", 32'(out_valid), 0);
                checkOutput("empty_pc", 32'(out_pc_plus4), 0);
                checkOutput("empty_instr", out_instr, 32'h0000_0013);
            end
        end
    end

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_count"}, 32'(count), 0);
        checkOutput({tag, "_in_ready"}, 32'(in_ready), 1);
        checkOutput({tag, "_out_valid"}, 32'(out_valid), 0);
        checkOutput({tag, "_out_instr"}, out_instr, 32'h0000_0013);
        checkOutput({tag, "_out_pc"}, 32'(out_pc_plus4), 0);
    endtask

    initial begin
        reset       = 1'b1;
        in_valid    = 1'b0;
        in_pc_plus4 = '0;
        in_instr    = '0;
        flush       = 1'b0;
        out_ready   = 1'b0;
        #2;
        checkResetState("reset");
        @(posedge clk);
        #1;
        reset     = 1'b0;
        monEnable = 1'b1;

        // Single push with ID stalled.
        applyStimulus(1, 10'd4, 32'h0050_0093, 0, 0);
        applyStimulus(0, 10'd0, 32'h0, 0, 0);
        checkOutput("single_count", 32'(count), 1);
        checkOutput("single_pc", 32'(out_pc_plus4), 4);

        // Fill to DEPTH, try an extra push, then drain in order.
        applyStimulus(1, 10'd8, 32'h0000_0808, 0, 0);
        applyStimulus(1, 10'd12, 32'h0000_0c0c, 0, 0);
        applyStimulus(1, 10'd16, 32'h0000_1010, 0, 0);
        checkOutput("full_count", 32'(count), 4);
        checkOutput("full_in_ready", 32'(in_ready), 0);
        applyStimulus(1, 10'd20, 32'h0000_1414, 0, 0);
        checkOutput("full_ignored_count", 32'(count), 4);
        for (int i = 0; i < 5; i++) applyStimulus(0, 10'd0, 32'h0, 1, 0);

        // Steady push+pop at occupancy 2 walks the pointers around the ring.
        applyStimulus(1, 10'd100, 32'h0000_0100, 0, 0);
        applyStimulus(1, 10'd104, 32'h0000_0104, 0, 0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1, PC_W'(108 + 4 * i), 32'h0000_0200 + i, 1, 0);
            checkOutput("steady_count", 32'(count), 2);
        end
        for (int i = 0; i < 3; i++) applyStimulus(0, 10'd0, 32'h0, 1, 0);

        // Flush with a simultaneous push drops everything, including that push.
        applyStimulus(1, 10'd40, 32'h0000_0040, 0, 0);
        applyStimulus(1, 10'd44, 32'h0000_0044, 0, 0);
        applyStimulus(1, 10'd48, 32'h0000_0048, 0, 0);
        applyStimulus(1, 10'd52, 32'h0000_0052, 0, 1);
        checkOutput("flush_count", 32'(count), 0);
        checkOutput("flush_out_valid", 32'(out_valid), 0);
        checkOutput("flush_out_instr", out_instr, 32'h0000_0013);
        applyStimulus(0, 10'd0, 32'h0, 1, 0);
        applyStimulus(0, 10'd0, 32'h0, 1, 0);

        // Asynchronous reset in the middle of a cycle with two entries held.
        applyStimulus(1, 10'd60, 32'h0000_0060, 0, 0);
        applyStimulus(1, 10'd64, 32'h0000_0064, 0, 0);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        checkOutput("prereset_count", 32'(count), 2);
        monEnable = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        checkResetState("async_reset");
        expQ.delete();
        occAtNeg = 0;
        bypassed = 1'b0;
        @(posedge clk);
        #1;
        reset     = 1'b0;
        monEnable = 1'b1;
        applyStimulus(1, 10'd68, 32'h0000_0068, 0, 0);
        applyStimulus(0, 10'd0, 32'h0, 1, 0);
        applyStimulus(0, 10'd0, 32'h0, 1, 0);

        // Random traffic, including occasional flushes.
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 9) < 7, PC_W'($urandom), $urandom,
                          $urandom_range(0, 1) == 1, $urandom_range(0, 19) == 0);
        end
        for (int i = 0; i < 8; i++) applyStimulus(0, 10'd0, 32'h0, 1, 0);

        monEnable = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
